// File: rtl/keypad_hex_entry.sv
// 4x4 matrix keypad scanner with debounce and a four-nibble hex entry register.
// Optional auto-repeat is compiled in when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_hex_entry #(
  parameter int SCAN_DIV    = 50000,
  parameter int DEBOUNCE    = 4,
  parameter int REPEAT_DLY  = 32,
  parameter int REPEAT_RATE = 8
) (
  input  logic        Digi_Sel_clk,
  input  logic        Digi_Sel_reset,
  input  logic [3:0]  kp_row_n,
  output logic [3:0]  kp_col_n,
  input  logic        entry_clr,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] entry_data,
  output logic        key_held
);

  // state     | meaning
  // S_IDLE    | no key accepted; waiting for a stable single key
  // S_PRESSED | key accepted and still held
  // S_REPEAT  | held past the first repeat delay (auto-repeat builds only)

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE + 1);
  localparam logic [4:0] RES_NONE = 5'h10;

  if (SCAN_DIV < 4) begin : g_chk_scan
    $error("keypad_hex_entry: SCAN_DIV must be at least 4");
  end
  if (DEBOUNCE < 1) begin : g_chk_deb
    $error("keypad_hex_entry: DEBOUNCE must be at least 1");
  end
  if (REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_chk_rpt
    $error("keypad_hex_entry: repeat intervals must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
`ifdef KEYPAD_AUTOREPEAT_EN
    S_REPEAT  = 2'd2,
`endif
    S_PRESSED = 2'd1
  } state_t;

  logic [3:0]        row_s1, row_s2;
  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col_idx;
  logic              slot_end, round_end;

  logic [3:0]        row_hit;
  logic              col_any, col_multi;
  logic [1:0]        col_row;

  logic              acc_any, acc_multi;
  logic [3:0]        acc_code;
  logic              mrg_any, mrg_multi;
  logic [3:0]        mrg_code;

  logic [4:0]        res, last_res;
  logic [DEB_W-1:0]  deb_cnt, deb_next;
  logic              stable;

  state_t            state;
  logic              accept, key_release, fire;

  always_ff @(posedge Digi_Sel_clk or posedge Digi_Sel_reset) begin
    if (Digi_Sel_reset) begin
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
    end else begin
      row_s1 <= kp_row_n;
      row_s2 <= row_s1;
    end
  end

  assign slot_end  = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign round_end = slot_end && (col_idx == 2'd3);

  always_ff @(posedge Digi_Sel_clk or posedge Digi_Sel_reset) begin
    if (Digi_Sel_reset) begin
      slot_cnt <= '0;
      col_idx  <= 2'd0;
      kp_col_n <= 4'b1110;
    end else if (slot_end) begin
      slot_cnt <= '0;
      col_idx  <= col_idx + 2'd1;
      kp_col_n <= {kp_col_n[2:0], kp_col_n[3]};
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  assign row_hit   = ~row_s2;
  assign col_any   = |row_hit;
  assign col_multi = (row_hit & (row_hit - 4'd1)) != 4'd0;

  always_comb begin
    col_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (row_hit[i]) col_row = 2'(i);
    end
  end

  // Merge this column's sample into the running round summary; any second hit
  // anywhere in the round makes the result NONE.
  assign mrg_any   = acc_any | col_any;
  assign mrg_multi = acc_multi | col_multi | (acc_any & col_any);
  assign mrg_code  = col_any ? {col_row, col_idx} : acc_code;
  assign res       = (!mrg_any || mrg_multi) ? RES_NONE : {1'b0, mrg_code};

  always_ff @(posedge Digi_Sel_clk or posedge Digi_Sel_reset) begin
    if (Digi_Sel_reset) begin
      acc_any   <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= 4'h0;
    end else if (round_end) begin
      acc_any   <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= 4'h0;
    end else if (slot_end) begin
      acc_any   <= mrg_any;
      acc_multi <= mrg_multi;
      acc_code  <= mrg_code;
    end
  end

  always_comb begin
    deb_next = DEB_W'(1);
    if (res == last_res) begin
      deb_next = (deb_cnt == DEB_W'(DEBOUNCE)) ? deb_cnt : deb_cnt + DEB_W'(1);
    end
  end

  assign stable = (deb_next == DEB_W'(DEBOUNCE));

  always_ff @(posedge Digi_Sel_clk or posedge Digi_Sel_reset) begin
    if (Digi_Sel_reset) begin
      deb_cnt  <= '0;
      last_res <= RES_NONE;
    end else if (round_end) begin
      deb_cnt  <= deb_next;
      last_res <= res;
    end
  end

  assign accept      = round_end && stable && !res[4] && (state == S_IDLE);
  assign key_release = round_end && stable && res[4];

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rep_cnt;
  logic             held_round, rpt_fire;

  // Only rounds that still see the accepted key advance the repeat timer.
  assign held_round = round_end && !res[4] && (res[3:0] == key_code) && (state != S_IDLE);
  assign rpt_fire   = held_round && (rep_cnt == RPT_W'(1));
  assign fire       = accept | rpt_fire;
`else
  assign fire       = accept;
`endif

  always_ff @(posedge Digi_Sel_clk or posedge Digi_Sel_reset) begin
    if (Digi_Sel_reset) begin
      state      <= S_IDLE;
      key_held   <= 1'b0;
      key_valid  <= 1'b0;
      key_code   <= 4'h0;
      entry_data <= 16'h0000;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt    <= '0;
`endif
    end else begin
      key_valid <= fire;
      if (fire) key_code <= res[3:0];

      if (entry_clr) begin
        entry_data <= fire ? {12'h000, res[3:0]} : 16'h0000;
      end else if (fire) begin
        entry_data <= {entry_data[11:0], res[3:0]};
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_PRESSED;
            key_held <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt  <= RPT_W'(REPEAT_DLY);
`endif
          end
        end
        S_PRESSED: begin
          if (key_release) begin
            state    <= S_IDLE;
            key_held <= 1'b0;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (held_round) begin
            if (rep_cnt == RPT_W'(1)) begin
              state   <= S_REPEAT;
              rep_cnt <= RPT_W'(REPEAT_RATE);
            end else begin
              rep_cnt <= rep_cnt - RPT_W'(1);
            end
          end
`endif
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        S_REPEAT: begin
          if (key_release) begin
            state    <= S_IDLE;
            key_held <= 1'b0;
          end else if (held_round) begin
            if (rep_cnt == RPT_W'(1)) begin
              rep_cnt <= RPT_W'(REPEAT_RATE);
            end else begin
              rep_cnt <= rep_cnt - RPT_W'(1);
            end
          end
        end
`endif
        default: begin
          state    <= S_IDLE;
          key_held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Scoreboard bench for keypad_hex_entry: a keypad model drives rows from the
// column strobes; expected key events are queued and checked by a monitor.
module tb_keypad_hex_entry;

  localparam int SD = 4;
  localparam int DB = 2;
  localparam int RD = 4;
  localparam int RR = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  kp_row_n;
  logic [3:0]  kp_col_n;
  logic        entry_clr = 1'b0;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry_data;
  logic        key_held;

  logic [15:0] keys = 16'h0000;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] exp_entry = 16'h0000;
  int          tests = 0;
  int          fails = 0;
  int          ev_count = 0;

  keypad_hex_entry #(
    .SCAN_DIV(SD), .DEBOUNCE(DB), .REPEAT_DLY(RD), .REPEAT_RATE(RR)
  ) dut (
    .Digi_Sel_clk   (clk),
    .Digi_Sel_reset (rst),
    .kp_row_n       (kp_row_n),
    .kp_col_n       (kp_col_n),
    .entry_clr      (entry_clr),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .entry_data     (entry_data),
    .key_held       (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    kp_row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !kp_col_n[c]) kp_row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst && key_valid) begin
      ev_count++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got code=%h data=%h, expected no event", key_code, entry_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (key_code !== mon_e.code || entry_data !== mon_e.data) begin
          fails++;
          $display("FAIL key_event: got code=%h data=%h, expected code=%h data=%h",
                   key_code, entry_data, mon_e.code, mon_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic sync_round();
    int n = 0;
    while (kp_col_n !== 4'b0111 && n < 200) begin @(negedge clk); n++; end
    while (kp_col_n !== 4'b1110 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL round_timeout: got no round boundary in %0d cycles, expected one", n);
    end
  endtask

  task automatic rounds(input int n);
    repeat (n) sync_round();
  endtask

  task automatic expect_event(input logic [3:0] code);
    exp_t e;
    exp_entry = {exp_entry[11:0], code};
    e.code = code;
    e.data = exp_entry;
    exp_q.push_back(e);
  endtask

  task automatic press_key(input logic [3:0] code, input int hold);
    expect_event(code);
    keys = 16'h0001 << code;
    rounds(hold);
    keys = 16'h0000;
    rounds(DB + 1);
  endtask

  task automatic clear_entry();
    @(negedge clk);
    entry_clr = 1'b1;
    @(negedge clk);
    entry_clr = 1'b0;
    exp_entry = 16'h0000;
    check("clear_entry", entry_data, 16'h0000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"},   {12'h0, kp_col_n},  16'h000E);
    check({tag, "_valid"}, {15'h0, key_valid}, 16'h0000);
    check({tag, "_code"},  {12'h0, key_code},  16'h0000);
    check({tag, "_entry"}, entry_data,         16'h0000);
    check({tag, "_held"},  {15'h0, key_held},  16'h0000);
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    rounds(1);

    // single key 6 held 3 rounds
    e0 = ev_count;
    press_key(4'h6, 3);
    check("key6_events", 16'(ev_count - e0), 16'd1);
    check("key6_code", {12'h0, key_code}, 16'h0006);
    check("key6_entry", entry_data, 16'h0006);

    // a different stable key while held gives no event
    expect_event(4'h5);
    keys = 16'h0001 << 5;
    rounds(3);
    check("held_in_pressed", {15'h0, key_held}, 16'h0001);
    keys = 16'h0001 << 7;
    rounds(3);
    keys = 16'h0000;
    rounds(DB + 1);
    check("held_after_release", {15'h0, key_held}, 16'h0000);
    check("switch_entry", entry_data, 16'h0065);

    // short press and multi-key presses are rejected
    e0 = ev_count;
    keys = 16'h0001 << 1; rounds(1);
    keys = 16'h0000;      rounds(3);
    keys = (16'h0001 << 1) | (16'h0001 << 6); rounds(3);
    keys = 16'h0000;      rounds(3);
    keys = (16'h0001 << 1) | (16'h0001 << 5); rounds(3);
    keys = 16'h0000;      rounds(3);
    check("reject_events", 16'(ev_count - e0), 16'd0);
    check("reject_entry", entry_data, 16'h0065);

    clear_entry();
    for (int k = 1; k <= 5; k++) press_key(4'(k), 3);
    check("seq_entry", entry_data, 16'h2345);

    clear_entry();
    for (int k = 1; k <= 4; k++) press_key(4'(k), 3);
    check("pre_clr_entry", entry_data, 16'h1234);

    // entry_clr in the same cycle as the key A acceptance
    begin
      exp_t e;
      exp_entry = 16'h000A;
      e.code = 4'hA;
      e.data = exp_entry;
      exp_q.push_back(e);
    end
    keys = 16'h0001 << 10;
    sync_round();
    begin
      int n = 0;
      while (kp_col_n !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
    end
    repeat (SD - 1) @(negedge clk);
    entry_clr = 1'b1;
    @(negedge clk);
    entry_clr = 1'b0;
    rounds(1);
    keys = 16'h0000;
    rounds(DB + 1);
    check("clr_coincident_entry", entry_data, 16'h000A);

    // key 3 held for 10 rounds
    clear_entry();
    e0 = ev_count;
`ifdef KEYPAD_AUTOREPEAT_EN
    repeat (4) expect_event(4'h3);
`else
    expect_event(4'h3);
`endif
    keys = 16'h0001 << 3;
    rounds(10);
    keys = 16'h0000;
    rounds(DB + 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("repeat_events", 16'(ev_count - e0), 16'd4);
    check("repeat_entry", entry_data, 16'h3333);
`else
    check("repeat_events", 16'(ev_count - e0), 16'd1);
    check("repeat_entry", entry_data, 16'h0003);
`endif

    // reset while a key is held in PRESSED
    expect_event(4'h6);
    keys = 16'h0001 << 6;
    rounds(3);
    check("held_before_reset", {15'h0, key_held}, 16'h0001);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midpress_reset");
    exp_entry = 16'h0000;
    expect_event(4'h6);
    rst = 1'b0;
    repeat (4 * SD * DB - 1) @(negedge clk);
    check("refire_not_early", {15'h0, key_valid}, 16'h0000);
    @(negedge clk);
    check("refire_on_time", {15'h0, key_valid}, 16'h0001);
    keys = 16'h0000;
    rounds(DB + 1);
    check("refire_entry", entry_data, 16'h0006);

    check("events_pending", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
